// File: rtl/cpeta_eval_pkg.sv
// rtl/cpeta_eval_pkg.sv - shared constants and FSM encoding for the CPETA error evaluator
package cpeta_eval_pkg;

  localparam int LFSR_W = 32;
  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cpeta.sv
// rtl/cpeta.sv - CPETA approximate adder: exact upper K bits, error-tolerant lower N-K bits
module cpeta #(
  parameter int N = 16,
  parameter int K = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  localparam int L = N - K;

  logic [L-1:0] lo;
  logic [K-1:0] hi;
  logic         sat;
  logic         cin;

  // Top lower bit predicts the carry into the exact segment; bits below it
  // saturate to 1 from the highest generate position downwards.
  always_comb begin
    sat = 1'b0;
    lo  = '0;
    cin = a[L-1] & b[L-1];
    lo[L-1] = a[L-1] ^ b[L-1];
    for (int i = L - 2; i >= 0; i--) begin
      sat   = sat | (a[i] & b[i]);
      lo[i] = sat | (a[i] ^ b[i]);
    end
    hi = a[N-1:L] + b[N-1:L] + K'(cin);
  end

  assign sum = {hi, lo};

endmodule

// File: rtl/lfsr32.sv
// rtl/lfsr32.sv - 32-bit Galois LFSR with load, step and zero-seed substitution
module lfsr32
  import cpeta_eval_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= {{(LFSR_W-1){1'b0}}, 1'b1};
    end else if (load) begin
      // an all-zero state would lock the register up
      value <= (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
    end else if (step) begin
      value <= {1'b0, value[LFSR_W-1:1]} ^ (value[0] ? LFSR_POLY : '0);
    end
  end

endmodule

// File: rtl/cpeta_error_eval.sv
// rtl/cpeta_error_eval.sv - measures CPETA error count, summed and maximum error distance
module cpeta_error_eval
  import cpeta_eval_pkg::*;
#(
  parameter int N  = 16,
  parameter int K  = 8,
  parameter int SW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SW-1:0]     num_samples,
  input  logic [31:0]       seed,
  input  logic              fixed_mode,
  input  logic [N-1:0]      op_a,
  input  logic [N-1:0]      op_b,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     err_count,
  output logic [N+SW-1:0]   err_dist_sum,
  output logic [N-1:0]      max_err_dist
);

  state_t state, state_nx;

  logic [SW-1:0]     cfg_n;
  logic [SW-1:0]     cnt;
  logic              cfg_fixed;
  logic [N-1:0]      cfg_a, cfg_b;
  logic [LFSR_W-1:0] lfsr_q;

  logic              v0, v1, v2;
  logic [N-1:0]      a0, b0;
  logic [N-1:0]      apx_c, s_apx, s_ex, ed;
  logic              accept, issue, last_issue;

  // busy still covers the done cycle, which also blocks a start there
  assign accept     = (state == IDLE) && start && !busy;
  assign issue      = (state == RUN);
  assign last_issue = issue && (cnt == cfg_n - SW'(1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (num_samples == '0) ? DONE : RUN;
      RUN:     if (last_issue) state_nx = DRAIN;
      // leave as the last sample reaches the accumulators; done is registered
      DRAIN:   if (v2 && !v1 && !v0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (issue),
    .seed  (seed),
    .value (lfsr_q)
  );

  cpeta #(.N(N), .K(K)) u_cpeta (
    .a   (a0),
    .b   (b0),
    .sum (apx_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_n        <= '0;
      cfg_fixed    <= 1'b0;
      cfg_a        <= '0;
      cfg_b        <= '0;
      cnt          <= '0;
      v0           <= 1'b0;
      v1           <= 1'b0;
      v2           <= 1'b0;
      a0           <= '0;
      b0           <= '0;
      s_apx        <= '0;
      s_ex         <= '0;
      ed           <= '0;
      err_count    <= '0;
      err_dist_sum <= '0;
      max_err_dist <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE) || (state == DONE);
      done  <= (state == DONE);

      if (accept) begin
        cfg_n        <= num_samples;
        cfg_fixed    <= fixed_mode;
        cfg_a        <= op_a;
        cfg_b        <= op_b;
        cnt          <= '0;
        err_count    <= '0;
        err_dist_sum <= '0;
        max_err_dist <= '0;
      end else if (v2) begin
        if (ed != '0) err_count <= err_count + SW'(1);
        err_dist_sum <= err_dist_sum + {{SW{1'b0}}, ed};
        if (ed > max_err_dist) max_err_dist <= ed;
      end

      if (issue) begin
        cnt <= cnt + SW'(1);
        a0  <= cfg_fixed ? cfg_a : lfsr_q[N-1:0];
        b0  <= cfg_fixed ? cfg_b : lfsr_q[2*N-1:N];
      end

      v0    <= issue;
      v1    <= v0;
      s_apx <= apx_c;
      s_ex  <= a0 + b0;
      v2    <= v1;
      ed    <= (s_ex >= s_apx) ? (s_ex - s_apx) : (s_apx - s_ex);
    end
  end

endmodule

// File: tb/tb_cpeta_error_eval.sv
// tb/tb_cpeta_error_eval.sv - scoreboard bench for cpeta_error_eval
module tb_cpeta_error_eval;

  localparam int N  = 16;
  localparam int K  = 8;
  localparam int SW = 16;
  localparam int TMO = 6000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [SW-1:0]   num_samples;
  logic [31:0]     seed;
  logic            fixed_mode;
  logic [N-1:0]    op_a, op_b;
  logic            busy, done;
  logic [SW-1:0]   err_count;
  logic [N+SW-1:0] err_dist_sum;
  logic [N-1:0]    max_err_dist;

  always #5 clk = ~clk;

  cpeta_error_eval #(.N(N), .K(K), .SW(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .seed         (seed),
    .fixed_mode   (fixed_mode),
    .op_a         (op_a),
    .op_b         (op_b),
    .busy         (busy),
    .done         (done),
    .err_count    (err_count),
    .err_dist_sum (err_dist_sum),
    .max_err_dist (max_err_dist)
  );

  typedef struct {
    int              lat;
    logic [SW-1:0]   cnt;
    logic [N+SW-1:0] sum;
    logic [N-1:0]    mx;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  function automatic logic [N-1:0] model_cpeta(input logic [N-1:0] a, input logic [N-1:0] b);
    int unsigned ua, ub, lo, hi, g;
    int j;
    ua = a; ub = b; g = ua & ub; j = -1;
    for (int i = N - K - 2; i >= 0; i--) if (g[i] && j < 0) j = i;
    lo = (ua ^ ub) & ((32'd1 << (N - K)) - 1);
    if (j >= 0) lo = lo | ((32'd1 << (j + 1)) - 1);
    hi = ((ua >> (N - K)) + (ub >> (N - K)) + ((g >> (N - K - 1)) & 1)) << (N - K);
    return N'(hi | lo);
  endfunction

  function automatic exp_t model_run(input logic [SW-1:0] s, input logic [31:0] sd,
                                     input bit fx, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    logic [31:0] l;
    logic [N-1:0] oa, ob, ex, ap, d;
    e.lat = (s == 0) ? 1 : int'(s) + 4;
    e.cnt = '0; e.sum = '0; e.mx = '0;
    l = (sd == 0) ? 32'd1 : sd;
    for (int i = 0; i < int'(s); i++) begin
      oa = fx ? a : l[N-1:0];
      ob = fx ? b : l[2*N-1:N];
      ex = oa + ob;
      ap = model_cpeta(oa, ob);
      d  = (ex > ap) ? ex - ap : ap - ex;
      if (d != 0) e.cnt = e.cnt + 1;
      e.sum = e.sum + d;
      if (d > e.mx) e.mx = d;
      l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
    end
    return e;
  endfunction

  function automatic exp_t mk(input int lat, input int c, input int s, input int m);
    exp_t e;
    e.lat = lat; e.cnt = SW'(c); e.sum = (N+SW)'(s); e.mx = N'(m);
    return e;
  endfunction

  // leaves the bench in the cycle after the accepting edge
  task automatic launch(input logic [SW-1:0] s, input logic [31:0] sd, input bit fx,
                        input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    num_samples = s; seed = sd; fixed_mode = fx; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_samples = '0; seed = '0;
    fixed_mode = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passed++;
    total++; if (err_count !== '0) $display("FAIL reset_cnt got %0d want 0", err_count); else passed++;
    total++; if (err_dist_sum !== '0) $display("FAIL reset_sum got %0d want 0", err_dist_sum); else passed++;
    total++; if (max_err_dist !== '0) $display("FAIL reset_max got %0d want 0", max_err_dist); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    logic [N-1:0] ta[4] = '{16'h00FF, 16'h007F, 16'h0080, 16'h1234};
    logic [N-1:0] tb[4] = '{16'h0001, 16'h007F, 16'h0080, 16'h0000};
    int ts[4] = '{5, 3, 4, 6};
    exp_t te[4];
    exp_t e;
    int cyc;
    te[0] = mk(9, 5, 5, 1); te[1] = mk(7, 3, 381, 127);
    te[2] = mk(8, 0, 0, 0); te[3] = mk(10, 0, 0, 0);
    for (int t = 0; t < 4; t++) begin
      launch(SW'(ts[t]), 32'h0, 1'b1, ta[t], tb[t]);
      sb.push_back(te[t]);
      total++; if (busy !== 1'b1) $display("FAIL fixed%0d_busy got %0b want 1", t, busy); else passed++;
      cyc = 0;
      while (!done && cyc < TMO) begin @(negedge clk); cyc++; end
      e = sb.pop_front();
      total++; if (cyc !== e.lat) $display("FAIL fixed%0d_lat got %0d want %0d", t, cyc, e.lat); else passed++;
      total++; if (err_count !== e.cnt) $display("FAIL fixed%0d_cnt got %0d want %0d", t, err_count, e.cnt); else passed++;
      total++; if (err_dist_sum !== e.sum) $display("FAIL fixed%0d_sum got %0d want %0d", t, err_dist_sum, e.sum); else passed++;
      total++; if (max_err_dist !== e.mx) $display("FAIL fixed%0d_max got %0d want %0d", t, max_err_dist, e.mx); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL fixed%0d_after done=%0b busy=%0b want 0 0", t, done, busy); else passed++;
    end
  endtask

  task automatic test_zero_and_busy_start();
    exp_t e;
    int cyc;
    launch('0, 32'h0, 1'b1, 16'h00FF, 16'h0001);
    sb.push_back(mk(1, 0, 0, 0));
    cyc = 0;
    while (!done && cyc < TMO) begin @(negedge clk); cyc++; end
    e = sb.pop_front();
    total++; if (cyc !== e.lat) $display("FAIL zero_lat got %0d want %0d", cyc, e.lat); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL zero_busy got %0b want 1", busy); else passed++;
    total++; if (err_count !== e.cnt || err_dist_sum !== e.sum || max_err_dist !== e.mx)
      $display("FAIL zero_res got %0d/%0d/%0d want 0/0/0", err_count, err_dist_sum, max_err_dist); else passed++;

    launch(SW'(10), 32'h0, 1'b1, 16'h007F, 16'h007F);
    sb.push_back(mk(14, 10, 1270, 127));
    cyc = 0;
    while (!done && cyc < TMO) begin
      @(negedge clk); cyc++;
      if (cyc == 3) begin start = 1'b1; num_samples = SW'(2); op_a = 16'h0080; op_b = 16'h0080; end
      if (cyc == 4) start = 1'b0;
    end
    e = sb.pop_front();
    total++; if (cyc !== e.lat) $display("FAIL busystart_lat got %0d want %0d", cyc, e.lat); else passed++;
    total++; if (err_count !== e.cnt) $display("FAIL busystart_cnt got %0d want %0d", err_count, e.cnt); else passed++;
    total++; if (err_dist_sum !== e.sum) $display("FAIL busystart_sum got %0d want %0d", err_dist_sum, e.sum); else passed++;
    total++; if (max_err_dist !== e.mx) $display("FAIL busystart_max got %0d want %0d", max_err_dist, e.mx); else passed++;
  endtask

  task automatic test_lfsr();
    logic [31:0] seeds[2] = '{32'h0, 32'h1};
    exp_t e;
    int cyc;
    for (int t = 0; t < 2; t++) begin
      launch(SW'(1000), seeds[t], 1'b0, '0, '0);
      sb.push_back(model_run(SW'(1000), seeds[t], 1'b0, '0, '0));
      cyc = 0;
      while (!done && cyc < TMO) begin @(negedge clk); cyc++; end
      e = sb.pop_front();
      total++; if (cyc !== e.lat) $display("FAIL lfsr%0d_lat got %0d want %0d", t, cyc, e.lat); else passed++;
      total++; if (err_count !== e.cnt) $display("FAIL lfsr%0d_cnt got %0d want %0d", t, err_count, e.cnt); else passed++;
      total++; if (err_dist_sum !== e.sum) $display("FAIL lfsr%0d_sum got %0d want %0d", t, err_dist_sum, e.sum); else passed++;
      total++; if (max_err_dist !== e.mx) $display("FAIL lfsr%0d_max got %0d want %0d", t, max_err_dist, e.mx); else passed++;
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int cyc;
    int seen;
    launch(SW'(1000), 32'hACE12345, 1'b0, '0, '0);
    sb.push_back(model_run(SW'(1000), 32'hACE12345, 1'b0, '0, '0));
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    void'(sb.pop_front());
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_ctl busy=%0b done=%0b want 0 0", busy, done); else passed++;
    total++; if (err_count !== '0) $display("FAIL midrst_cnt got %0d want 0", err_count); else passed++;
    total++; if (err_dist_sum !== '0) $display("FAIL midrst_sum got %0d want 0", err_dist_sum); else passed++;
    total++; if (max_err_dist !== '0) $display("FAIL midrst_max got %0d want 0", max_err_dist); else passed++;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (done || busy) seen++; end
    total++; if (seen !== 0) $display("FAIL midrst_quiet got %0d active cycles want 0", seen); else passed++;

    launch(SW'(5), 32'h0, 1'b1, 16'h00FF, 16'h0001);
    sb.push_back(mk(9, 5, 5, 1));
    cyc = 0;
    while (!done && cyc < TMO) begin @(negedge clk); cyc++; end
    e = sb.pop_front();
    total++; if (cyc !== e.lat) $display("FAIL rerun_lat got %0d want %0d", cyc, e.lat); else passed++;
    total++; if (err_count !== e.cnt || err_dist_sum !== e.sum || max_err_dist !== e.mx)
      $display("FAIL rerun_res got %0d/%0d/%0d want %0d/%0d/%0d", err_count, err_dist_sum, max_err_dist, e.cnt, e.sum, e.mx); else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    launch(SW'(3), 32'h0, 1'b1, 16'h007F, 16'h007F);
    sb.push_back(mk(7, 3, 381, 127));
    cyc = 0;
    while (!done && cyc < TMO) begin @(negedge clk); cyc++; end
    e = sb.pop_front();
    total++; if (cyc !== e.lat) $display("FAIL b2b1_lat got %0d want %0d", cyc, e.lat); else passed++;
    total++; if (err_dist_sum !== e.sum) $display("FAIL b2b1_sum got %0d want %0d", err_dist_sum, e.sum); else passed++;
    // start raised in the done cycle and held one more cycle
    num_samples = SW'(2); fixed_mode = 1'b1; op_a = 16'h00FF; op_b = 16'h0001; start = 1'b1;
    sb.push_back(mk(6, 2, 2, 1));
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL b2b_ignored busy got %0b want 0", busy); else passed++;
    total++; if (err_count !== SW'(3)) $display("FAIL b2b_held cnt got %0d want 3", err_count); else passed++;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept busy got %0b want 1", busy); else passed++;
    cyc = 0;
    while (!done && cyc < TMO) begin @(negedge clk); cyc++; end
    e = sb.pop_front();
    total++; if (cyc !== e.lat) $display("FAIL b2b2_lat got %0d want %0d", cyc, e.lat); else passed++;
    total++; if (err_count !== e.cnt || err_dist_sum !== e.sum || max_err_dist !== e.mx)
      $display("FAIL b2b2_res got %0d/%0d/%0d want %0d/%0d/%0d", err_count, err_dist_sum, max_err_dist, e.cnt, e.sum, e.mx); else passed++;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_zero_and_busy_start();
    test_lfsr();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpeta_error_eval.md
# cpeta_error_eval

Self-checking error-characterisation controller for the CPETA approximate adder. On `start` it runs a configurable number of operand pairs through an internal CPETA instance and an exact reference adder. It accumulates error count, summed error distance and maximum error distance, then pulses `done`. It sits beside the adder library as the on-chip measurement harness used to sweep N/K configurations.

## Interface
- `N`, 16: operand width; legal range 4 < N ≤ 16, because the operands are drawn from a 32-bit LFSR.
- `K`, 8: CPETA exact upper-segment width; legal range 1 ≤ K ≤ N-4.
- `SW`, 16: width of the sample counter and of `num_samples`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `num_samples`  in  SW  number of operand pairs; sampled with `start`.
- `seed`  in  32  LFSR seed; sampled with `start`.
- `fixed_mode`  in  1  1 = every sample uses `op_a`/`op_b`; sampled with `start`.
- `op_a`, `op_b`  in  N  fixed operands; sampled with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted through the `done` cycle.
- `done`  out  1  single-cycle completion pulse.
- `err_count`  out  SW  number of samples with error distance (ED) ≠ 0.
- `err_dist_sum`  out  N+SW  sum of ED over all samples.
- `max_err_dist`  out  N  largest ED seen.

## Operation
- **Error distance.** ED = |((A+B) mod 2^N) − CPETA(A,B)|, computed at N bits. The exact carry-out is discarded because CPETA has no carry output.
- **Operand source.**
  - LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - `A` = lfsr[N-1:0], `B` = lfsr[2N-1:N]. The LFSR steps once per issued sample.
  - A seed of 0 is replaced by 32'h1.
- **Pipeline.**
  - S0: operand register.
  - S1: register both the approximate sum and the exact sum.
  - S2: register ED and its valid bit.
  - S3: update the accumulators.
- **FSM states.**
  - IDLE: `busy`=0. On `start`=1:
    - latch the configuration;
    - clear all three results to 0;
    - if `num_samples`=0, go to DONE; otherwise go to RUN.
  - RUN: issue one sample per cycle. Leave for DRAIN in the cycle the `num_samples`-th sample is issued.
  - DRAIN: wait until the S3 valid bit has retired the last sample, then go to DONE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- **Results.** Held stable from `done` until the next accepted `start`.
- **Arithmetic.**
  - `err_count` increments by 1 when ED ≠ 0.
  - `err_dist_sum` accumulates zero-extended ED. Its N+SW width cannot overflow.
  - `max_err_dist` updates when ED > current value (unsigned compare).
- **Start while busy.** `start` while `busy` is ignored, and configuration inputs are not re-sampled.

## Timing
- **Reset.** `rst_n`=0 at a clock edge forces IDLE and clears all pipeline valid bits. All outputs reset to 0: `busy`, `done`, `err_count`, `err_dist_sum`, `max_err_dist`.
- **Reset mid-run.** Same behaviour; the run is abandoned and no `done` is produced.
- **Latency.** Let edge 0 be the edge that accepts `start`.
  - `num_samples`=S>0: `done` is high in the cycle after edge S+4. Throughput is 1 sample/cycle.
  - S=0: `done` is high in the cycle after edge 1.
- **Back-to-back runs.** `start` asserted during the `done` cycle is ignored. The earliest accepted `start` is the cycle after `done`.

## Structure
- **Shared package (`cpeta_eval_pkg`).** Holds:
  - FSM state encoding: IDLE, RUN, DRAIN, DONE;
  - LFSR polynomial constant 32'h80200003;
  - LFSR width 32.
- **Sub-modules.**
  - `lfsr32`: load, step and seed-zero substitution.
  - The existing CPETA module, instantiated as the approximate datapath.
  - The exact sum is a behavioural N-bit addition.

## Test plan
Use the defaults N=16, K=8 unless stated.
- Fixed mode, A=0x00FF, B=0x0001, S=5 → `err_count`=5, `err_dist_sum`=5, `max_err_dist`=1; `done` in the cycle after edge 9.
- Fixed mode, A=0x007F, B=0x007F, S=3 → approximate sum 0x007F vs exact 0x00FE; `err_count`=3, `err_dist_sum`=381, `max_err_dist`=127.
- Fixed mode, A=0x0080, B=0x0080, S=4 → `err_count`=0, `err_dist_sum`=0, `max_err_dist`=0 (Cin path exact). Also A=0x1234, B=0x0000 → all zero.
- S=0 → `done` in the cycle after edge 1, all results 0. A `start` pulse during `busy` with a different S → no effect on the cycle count or results.
- LFSR mode, seed=0 and seed=1, S=1000 → identical results in both runs, and both match the bench's software model of the same LFSR and CPETA.
- `rst_n` pulled low at sample 500 of a 1000-sample run → next cycle all outputs 0, no `done`. A fresh run then completes normally.
